byte_swap_arbiter: RTL and testbench

Shared byte-reorder unit with round-robin arbitration between two requester streams. Each requester presents a 32-bit word plus a 2-bit reorder mode. The granted word is reordered and captured into a one-entry output register drained by a valid/ready consumer. It sits in front of the byte-reversal datapath so two producers (e.g. load and store endian-fixup paths) share one reorder stage instead of instantiating two.

---
 rtl/byte_swap_arbiter.sv | 125 ++++++++++++
 tb/tb_byte_swap_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/byte_swap_arbiter.sv
// byte_swap_arbiter
//   Two requesters share one byte-reorder stage. A round-robin arbiter picks
//   one requester per cycle. The granted word is reordered and captured into
//   a single output register that a valid/ready consumer drains.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   in0_valid/ready       requester 0 handshake
//   in0_data[31:0]        requester 0 word
//   in0_mode[1:0]         requester 0 reorder mode
//                         (0 pass, 1 byte reverse, 2 swap bytes in halfwords,
//                         3 halfword swap)
//   in1_*                 the same ports for requester 1
//   out_valid/ready       output handshake
//   out_data[31:0]        reordered word
//   out_src               index of the requester that produced out_data
//   xfer_count[15:0]      completed output transfers, wraps modulo 2^16
module byte_swap_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        in0_valid,
  output logic        in0_ready,
  input  logic [31:0] in0_data,
  input  logic [1:0]  in0_mode,
  input  logic        in1_valid,
  output logic        in1_ready,
  input  logic [31:0] in1_data,
  input  logic [1:0]  in1_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_src,
  output logic [15:0] xfer_count
);

  function automatic logic [31:0] reorder(input logic [31:0] w, input logic [1:0] m);
    logic [31:0] r;
    case (m)
      2'd0:    r = w;
      2'd1:    r = {w[7:0], w[15:8], w[23:16], w[31:24]};
      2'd2:    r = {w[23:16], w[31:24], w[7:0], w[15:8]};
      default: r = {w[15:0], w[31:16]};
    endcase
    return r;
  endfunction

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q,  out_data_d;
  logic        out_src_q,   out_src_d;
  logic        last_q,      last_d;
  logic [15:0] xfer_q,      xfer_d;

  logic        can_accept;
  logic        gnt_vld;
  logic        gnt_idx;
  logic        accept;
  logic        drain;
  logic [31:0] sel_data;
  logic [1:0]  sel_mode;

  // Arbitration: on a tie the requester that did not win last time goes next.
  always_comb begin
    gnt_vld = in0_valid | in1_valid;
    gnt_idx = 1'b0;
    if (in0_valid && in1_valid) begin
      gnt_idx = ~last_q;
    end else if (in1_valid) begin
      gnt_idx = 1'b1;
    end
  end

  // Readies are forced low while reset is asserted so nothing is consumed
  // from a requester during a reset cycle.
  assign can_accept = ~out_valid_q | out_ready;
  assign in0_ready  = ~rst & can_accept & gnt_vld & (gnt_idx == 1'b0) & in0_valid;
  assign in1_ready  = ~rst & can_accept & gnt_vld & (gnt_idx == 1'b1) & in1_valid;
  assign accept     = in0_ready | in1_ready;
  assign drain      = out_valid_q & out_ready;

  assign sel_data = gnt_idx ? in1_data : in0_data;
  assign sel_mode = gnt_idx ? in1_mode : in0_mode;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    last_d      = last_q;
    xfer_d      = xfer_q;
    if (accept) begin
      // Covers both a plain accept and a same-cycle drain plus refill.
      out_valid_d = 1'b1;
      out_data_d  = reorder(sel_data, sel_mode);
      out_src_d   = gnt_idx;
      last_d      = gnt_idx;
    end else if (drain) begin
      // Data and source stay stale; only the valid flag drops.
      out_valid_d = 1'b0;
    end
    if (drain) begin
      xfer_d = xfer_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
      out_src_q   <= 1'b0;
      last_q      <= 1'b1;
      xfer_q      <= 16'd0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      last_q      <= last_d;
      xfer_q      <= xfer_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_src    = out_src_q;
  assign xfer_count = xfer_q;

endmodule

// File: tb/tb_byte_swap_arbiter.sv
module tb_byte_swap_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in0_valid, in0_ready;
  logic [31:0] in0_data;
  logic [1:0]  in0_mode;
  logic        in1_valid, in1_ready;
  logic [31:0] in1_data;
  logic [1:0]  in1_mode;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic        out_src;
  logic [15:0] xfer_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  byte_swap_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .in0_valid  (in0_valid),
    .in0_ready  (in0_ready),
    .in0_data   (in0_data),
    .in0_mode   (in0_mode),
    .in1_valid  (in1_valid),
    .in1_ready  (in1_ready),
    .in1_data   (in1_data),
    .in1_mode   (in1_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_src    (out_src),
    .xfer_count (xfer_count)
  );

  typedef struct {
    logic        v0;
    logic [31:0] d0;
    logic [1:0]  m0;
    logic        v1;
    logic [31:0] d1;
    logic [1:0]  m1;
    logic        ordy;
    logic        er0;
    logic        er1;
    logic        eov;
    logic [31:0] eod;
    logic        esrc;
    logic [15:0] ecnt;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v0, input logic [31:0] d0, input logic [1:0] m0,
                       input logic v1, input logic [31:0] d1, input logic [1:0] m1,
                       input logic ordy);
    in0_valid = v0; in0_data = d0; in0_mode = m0;
    in1_valid = v1; in1_data = d1; in1_mode = m1;
    out_ready = ordy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic r0, input logic r1, input logic ov,
                           input logic [31:0] od, input logic src, input logic [15:0] cnt);
    chk({tag, ".in0_ready"},  {31'd0, in0_ready}, {31'd0, r0});
    chk({tag, ".in1_ready"},  {31'd0, in1_ready}, {31'd0, r1});
    chk({tag, ".out_valid"},  {31'd0, out_valid}, {31'd0, ov});
    chk({tag, ".out_data"},   out_data, od);
    chk({tag, ".out_src"},    {31'd0, out_src}, {31'd0, src});
    chk({tag, ".xfer_count"}, {16'd0, xfer_count}, {16'd0, cnt});
  endtask

  initial begin
    // v0 d0 m0 | v1 d1 m1 | ordy | r0 r1 ov od src cnt
    tbl[0]  = '{1'b0, 32'h0,        2'd0, 1'b0, 32'h0,        2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 16'd0};
    tbl[1]  = '{1'b1, 32'h11223344, 2'd0, 1'b0, 32'h0,        2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b0, 16'd0};
    tbl[2]  = '{1'b1, 32'h11223344, 2'd1, 1'b0, 32'h0,        2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h11223344, 1'b0, 16'd0};
    tbl[3]  = '{1'b1, 32'h11223344, 2'd2, 1'b0, 32'h0,        2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h44332211, 1'b0, 16'd1};
    tbl[4]  = '{1'b1, 32'h11223344, 2'd3, 1'b0, 32'h0,        2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h22114433, 1'b0, 16'd2};
    tbl[5]  = '{1'b0, 32'h0,        2'd0, 1'b0, 32'h0,        2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h33441122, 1'b0, 16'd3};
    tbl[6]  = '{1'b0, 32'h0,        2'd0, 1'b0, 32'h0,        2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h33441122, 1'b0, 16'd4};
    tbl[7]  = '{1'b0, 32'h0,        2'd0, 1'b1, 32'hCAFEF00D, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h33441122, 1'b0, 16'd4};
    tbl[8]  = '{1'b1, 32'hA0A0A0A0, 2'd0, 1'b1, 32'hB1B1B1B1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0DF0FECA, 1'b1, 16'd4};
    tbl[9]  = '{1'b1, 32'hA0A0A0A0, 2'd0, 1'b1, 32'hB1B1B1B1, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA0A0A0A0, 1'b0, 16'd5};
    tbl[10] = '{1'b1, 32'hA0A0A0A0, 2'd0, 1'b1, 32'hB1B1B1B1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hB1B1B1B1, 1'b1, 16'd6};
    tbl[11] = '{1'b1, 32'hA0A0A0A0, 2'd0, 1'b1, 32'hB1B1B1B1, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA0A0A0A0, 1'b0, 16'd7};
    tbl[12] = '{1'b0, 32'h0,        2'd0, 1'b0, 32'h0,        2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hB1B1B1B1, 1'b1, 16'd8};
    tbl[13] = '{1'b0, 32'h0,        2'd0, 1'b0, 32'h0,        2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hB1B1B1B1, 1'b1, 16'd9};

    // Reset: outputs cleared, readies held low even with a requester valid.
    rst = 1'b1;
    drive(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 2'd0, 1'b0);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      drive(i == 1, 32'hDEADBEEF, 2'd0, i == 2, 32'hFEEDFACE, 2'd0, 1'b1);
      @(negedge clk);
      chk_state($sformatf("reset%0d", i), 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 16'd0);
      next_cycle();
    end
    rst = 1'b0;

    // Table: idle, mode sweep, single in1 request, two-way contention, drain.
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].v0, tbl[i].d0, tbl[i].m0, tbl[i].v1, tbl[i].d1, tbl[i].m1, tbl[i].ordy);
      @(negedge clk);
      chk_state($sformatf("vec%0d", i), tbl[i].er0, tbl[i].er1, tbl[i].eov,
                tbl[i].eod, tbl[i].esrc, tbl[i].ecnt);
      next_cycle();
    end

    // Backpressure: accept one word, then stall for 4 cycles.
    drive(1'b1, 32'h01020304, 2'd1, 1'b0, 32'h0, 2'd0, 1'b1);
    @(negedge clk);
    chk_state("bp_acc", 1'b1, 1'b0, 1'b0, 32'hB1B1B1B1, 1'b1, 16'd9);
    next_cycle();
    drive(1'b1, 32'h05060708, 2'd0, 1'b1, 32'h0A0B0C0D, 2'd3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_state($sformatf("bp_stall%0d", i), 1'b0, 1'b0, 1'b1, 32'h04030201, 1'b0, 16'd9);
      next_cycle();
    end
    // Release: the held word drains while requester 1 (last was 0) refills.
    out_ready = 1'b1;
    @(negedge clk);
    chk_state("bp_release", 1'b0, 1'b1, 1'b1, 32'h04030201, 1'b0, 16'd9);
    next_cycle();
    drive(1'b1, 32'h05060708, 2'd0, 1'b0, 32'h0, 2'd0, 1'b1);
    @(negedge clk);
    chk_state("bp_refill", 1'b1, 1'b0, 1'b1, 32'h0C0D0A0B, 1'b1, 16'd10);
    next_cycle();
    drive(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 2'd0, 1'b1);
    @(negedge clk);
    chk_state("bp_last", 1'b0, 1'b0, 1'b1, 32'h05060708, 1'b0, 16'd11);
    next_cycle();
    @(negedge clk);
    chk_state("bp_empty", 1'b0, 1'b0, 1'b0, 32'h05060708, 1'b0, 16'd12);
    next_cycle();

    // Reset mid-stall: held word is dropped and the pointer returns to 1.
    drive(1'b0, 32'h0, 2'd0, 1'b1, 32'h12345678, 2'd0, 1'b0);
    next_cycle();
    drive(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 2'd0, 1'b0);
    @(negedge clk);
    chk_state("mid_held", 1'b0, 1'b0, 1'b1, 32'h12345678, 1'b1, 16'd12);
    next_cycle();
    rst = 1'b1;
    drive(1'b1, 32'h0, 2'd0, 1'b1, 32'h0, 2'd0, 1'b1);
    @(negedge clk);
    chk({"mid_rst.in0_ready"}, {31'd0, in0_ready}, 32'd0);
    chk({"mid_rst.in1_ready"}, {31'd0, in1_ready}, 32'd0);
    next_cycle();
    rst = 1'b0;
    drive(1'b1, 32'h55667788, 2'd1, 1'b1, 32'h99AABBCC, 2'd0, 1'b1);
    @(negedge clk);
    chk_state("post_rst_tie", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 16'd0);
    next_cycle();
    drive(1'b0, 32'h0, 2'd0, 1'b1, 32'h99AABBCC, 2'd0, 1'b1);
    @(negedge clk);
    chk_state("post_rst_out", 1'b0, 1'b1, 1'b1, 32'h88776655, 1'b0, 16'd0);
    next_cycle();

    // Counter wrap: fresh reset, then 65537 transfers from requester 0.
    rst = 1'b1;
    drive(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 2'd0, 1'b1);
    next_cycle();
    rst = 1'b0;
    drive(1'b1, 32'h00C0FFEE, 2'd0, 1'b0, 32'h0, 2'd0, 1'b1);
    for (int i = 0; i < 65537; i++) begin
      next_cycle();
    end
    drive(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 2'd0, 1'b1);
    next_cycle();
    @(negedge clk);
    chk_state("wrap", 1'b0, 1'b0, 1'b0, 32'h00C0FFEE, 1'b0, 16'd1);
    // A stalled word must not count.
    drive(1'b1, 32'h0BADF00D, 2'd0, 1'b0, 32'h0, 2'd0, 1'b1);
    next_cycle();
    drive(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
    end
    @(negedge clk);
    chk_state("wrap_stall", 1'b0, 1'b0, 1'b1, 32'h0BADF00D, 1'b0, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
